// File: rtl/count_arbiter_pkg.sv
// Shared definitions for the two-requester count arbiter: FSM states,
// requester count and the grant one-hot helper.
package count_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/count_arbiter_count_unit.sv
// Shared up-counter: synchronous clear has priority over enable,
// asynchronous active-low reset to zero.
module count_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/count_arbiter.sv
// Two-requester arbiter that lends a shared counter to one requester at a time.
// Define COUNT_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise req[0] wins.
module count_arbiter
    import count_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   term0,
    input  logic [WIDTH-1:0]   term1,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic [WIDTH-1:0]   count,
    output logic [NUM_REQ-1:0] done
);

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic             winner;
    logic             grant;
    logic             abort;
    logic             hit;
    logic             cnt_clr;
    logic             cnt_en;
    logic [WIDTH-1:0] term_q;

    assign grant   = (state == IDLE) && (req != '0);
    assign abort   = (state == RUN) && !req[owner];
    assign hit     = (count == term_q);
    assign cnt_clr = grant;
    assign cnt_en  = (state == RUN) && !abort && !hit;

`ifdef COUNT_ARB_ROUND_ROBIN_EN
    // last holds the most recently served requester; a tie goes to the other one
    logic last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b1;
        end else if (abort || (state == DONE)) begin
            last <= owner;
        end
    end

    assign winner = (req == '1) ? ~last : req[1];
`else
    assign winner = ~req[0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= 1'b0;
        end else if (grant) begin
            owner <= winner;
        end
    end

    // Terminal count is captured once so later term changes cannot disturb a run
    always_ff @(posedge clk) begin
        if (grant) begin
            term_q <= winner ? term1 : term0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort wins over completion so a dropped request never sees a done pulse
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        gnt  = '0;
        done = '0;
        if (busy) begin
            gnt = onehot(owner);
        end
        if (state == DONE) begin
            done = onehot(owner);
        end
    end

    count_unit #(
        .WIDTH (WIDTH)
    ) u_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

endmodule

// File: tb/tb_count_arbiter.sv
// Bench for count_arbiter: cycle-indexed reference model plus directed scenarios.
module tb_count_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [3:0] term0 = 4'd0;
    logic [3:0] term1 = 4'd0;
    logic [1:0] gnt;
    logic       busy;
    logic [3:0] count;
    logic [1:0] done;

    int n_chk = 0;
    int n_fail = 0;

    count_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .term0 (term0),
        .term1 (term1),
        .gnt   (gnt),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] r, input int last);
`ifdef COUNT_ARB_ROUND_ROBIN_EN
        if (r == 2'b11) return (last == 0) ? 1 : 0;
`endif
        return r[0] ? 0 : 1;
    endfunction

    // Reference model: a grant at cycle k with terminal T owns the counter for
    // cycles k..k+T+1; count is min(cycles since grant, T), done at k+T+1.
    int cyc = 0;
    int m_owner = -1;
    int m_k = 0;
    int m_T = 0;
    int m_idle_cnt = 0;
    int m_last = 1;
    int m_d;
    int e_g, e_b, e_c, e_d;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_owner = -1;
            m_idle_cnt = 0;
            m_last = 1;
        end else if (m_owner < 0) begin
            if (req != 2'b00) begin
                m_owner = pick(req, m_last);
                m_k = cyc;
                m_T = (m_owner == 0) ? int'(term0) : int'(term1);
            end
        end else begin
            m_d = cyc - m_k;
            if (m_d <= m_T + 1 && !req[m_owner]) begin
                m_idle_cnt = (m_d - 1 < m_T) ? m_d - 1 : m_T;
                m_last = m_owner;
                m_owner = -1;
            end else if (m_d >= m_T + 2) begin
                m_idle_cnt = m_T;
                m_last = m_owner;
                m_owner = -1;
            end
        end
        if (m_owner < 0) begin
            e_g = 0; e_b = 0; e_d = 0; e_c = m_idle_cnt;
        end else begin
            m_d = cyc - m_k;
            e_g = 1 << m_owner;
            e_b = 1;
            e_c = (m_d < m_T) ? m_d : m_T;
            e_d = (m_d == m_T + 1) ? e_g : 0;
        end
        #1;
        chk("model_gnt", int'(gnt), e_g);
        chk("model_busy", int'(busy), e_b);
        chk("model_count", int'(count), e_c);
        chk("model_done", int'(done), e_d);
    end

    logic [1:0] sg [16];
    logic [3:0] sc [16];
    logic [1:0] sd [16];
    logic       sb [16];
    logic [1:0] grants [3];
    logic [1:0] prev;
    int         ng;
    int         done_seen;

    task automatic sample(input int i);
        @(negedge clk);
        sg[i] = gnt;
        sc[i] = count;
        sd[i] = done;
        sb[i] = busy;
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b1;
        @(negedge clk);

        // single request, term 3
        req = 2'b01; term0 = 4'd3;
        for (int i = 0; i < 6; i++) begin
            sample(i);
            if (i == 4) req = 2'b00;
        end
        chk("single_gnt", int'(sg[0]), 1);
        for (int i = 0; i < 5; i++) chk("single_count", int'(sc[i]), (i < 3) ? i : 3);
        chk("single_done_early", int'(sd[3]), 0);
        chk("single_done", int'(sd[4]), 1);
        chk("single_release_gnt", int'(sg[5]), 0);
        chk("single_release_done", int'(sd[5]), 0);

        // zero terminal count on requester 1
        req = 2'b10; term1 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            sample(i);
            if (i == 1) req = 2'b00;
        end
        chk("zero_gnt", int'(sg[0]), 2);
        chk("zero_done_grant_cycle", int'(sd[0]), 0);
        chk("zero_done", int'(sd[1]), 2);
        chk("zero_count", int'(sc[1]), 0);
        chk("zero_release", int'(sg[2]), 0);

        // abort at count 4
        req = 2'b01; term0 = 4'd9; done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            sample(i);
            if (sd[i] != 2'b00) done_seen = 1;
            if (i == 4) req = 2'b00;
        end
        chk("abort_count_before", int'(sc[4]), 4);
        chk("abort_gnt", int'(sg[5]), 0);
        chk("abort_busy", int'(sb[5]), 0);
        chk("abort_count_held", int'(sc[7]), 4);
        chk("abort_no_done", done_seen, 0);

        // term change after grant
        req = 2'b01; term0 = 4'd2;
        for (int i = 0; i < 6; i++) begin
            sample(i);
            if (i == 1) term0 = 4'd7;
            if (sd[i] != 2'b00) req = 2'b00;
        end
        chk("term_chg_done_early", int'(sd[2]), 0);
        chk("term_chg_done", int'(sd[3]), 1);
        chk("term_chg_count", int'(sc[3]), 2);
        chk("term_chg_release", int'(sg[4]), 0);

        // reset in the middle of a run
        req = 2'b01; term0 = 4'd9; done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            sample(i);
            if (sd[i] != 2'b00) done_seen = 1;
        end
        chk("rst_mid_count_before", int'(sc[5]), 5);
        rst = 1'b0;
        #1;
        chk("rst_mid_count", int'(count), 0);
        chk("rst_mid_gnt", int'(gnt), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        req = 2'b00;
        repeat (2) begin
            @(negedge clk);
            if (done != 2'b00) done_seen = 1;
        end
        chk("rst_mid_no_done", done_seen, 0);
        rst = 1'b1;
        @(negedge clk);

        // simultaneous requests held high
        req = 2'b11; term0 = 4'd1; term1 = 4'd1;
        prev = 2'b00; ng = 0;
        for (int i = 0; i < 3; i++) grants[i] = 2'b00;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (gnt != 2'b00 && prev == 2'b00 && ng < 3) begin
                grants[ng] = gnt;
                ng++;
            end
            prev = gnt;
        end
        req = 2'b00;
        chk("tie_grant_count", ng, 3);
`ifdef COUNT_ARB_ROUND_ROBIN_EN
        chk("tie_grant0", int'(grants[0]), 1);
        chk("tie_grant1", int'(grants[1]), 2);
        chk("tie_grant2", int'(grants[2]), 1);
`else
        chk("tie_grant0", int'(grants[0]), 1);
        chk("tie_grant1", int'(grants[1]), 1);
        chk("tie_grant2", int'(grants[2]), 1);
`endif
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/count_arbiter.md
COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, shared counter width; term inputs and count output are WIDTH bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: req  input  2  per-requester level request; bit i held high while requester i wants the counter.
REQ-005 Port: term0  input  WIDTH  terminal count for requester 0, sampled at grant.
REQ-006 Port: term1  input  WIDTH  terminal count for requester 1, sampled at grant.
REQ-007 Port: gnt  output  2  one-hot grant; at most one bit high.
REQ-008 Port: busy  output  1  high in RUN and DONE states.
REQ-009 Port: count  output  WIDTH  current shared counter value.
REQ-010 Port: done  output  2  one-cycle completion pulse to the granted requester.

Function
REQ-011 FSM states SHALL be IDLE, RUN, DONE; encoding 2 bits.
REQ-012 IDLE: if req != 0 at a rising edge, SHALL select winner, set gnt to winner one-hot, latch winner's term, clear count to 0, enter RUN (grant visible 1 cycle after req sampled).
REQ-013 IDLE with req == 0: SHALL hold gnt=0, count unchanged, done=0.
REQ-014 RUN: if count == latched term, SHALL enter DONE, drive done = gnt for exactly one cycle, hold count; else count SHALL increment by 1.
REQ-015 Count never wraps in RUN: max term 2^WIDTH-1 stops at all-ones.
REQ-016 term = 0: count 0 matches immediately; done SHALL pulse on the edge after grant.
REQ-017 Latency: grant at edge k, done high after edge k+T+1, back in IDLE after edge k+T+2 (T = latched term).
REQ-018 DONE: SHALL clear gnt and done, update last-served pointer to the finished requester, return to IDLE.
REQ-019 Abort: if the granted requester's req bit drops during RUN, SHALL return to IDLE next edge, gnt=0, no done pulse, count held, last-served pointer updated.
REQ-020 Changes to term0/term1 after grant SHALL NOT affect the running sequence.
REQ-021 Requests from the non-granted requester during RUN/DONE SHALL be ignored until IDLE; no queuing.
REQ-022 gnt SHALL never have both bits high; done SHALL be a subset of gnt's previous value.

Reset
REQ-023 rst low SHALL immediately force state=IDLE, gnt=0, done=0, count=0, busy=0, last-served pointer=1 (so requester 0 wins first under round-robin).
REQ-024 Reset mid-RUN SHALL abort without a done pulse; operation resumes on first edge after rst rises.

Configuration
REQ-025 Macro COUNT_ARB_ROUND_ROBIN_EN defined: simultaneous requests SHALL go to the requester not in the last-served pointer.
REQ-026 Macro undefined: fixed priority, req[0] SHALL always win ties; pointer logic not synthesized.

Structure
REQ-027 Shared package SHALL hold FSM state typedef (IDLE/RUN/DONE) and the requester count constant (2).
REQ-028 Counter SHALL be a sub-module count_unit (WIDTH bits, clear, enable, asynchronous active-low reset); arbitration/FSM stays in count_arbiter.

Verification
REQ-029 Reset: rst=0 mid-RUN at count=5 -> count=0, gnt=00, busy=0 immediately, no done.
REQ-030 Single request: req=01, term0=3 -> gnt=01, count 0,1,2,3, done=01 one cycle, then gnt=00.
REQ-031 Zero term: req=10, term1=0 -> gnt=10, done=10 on next edge, count stays 0.
REQ-032 Tie with COUNT_ARB_ROUND_ROBIN_EN: req=11 held, term0=term1=1 -> grants alternate 01,10,01; without macro -> always 01.
REQ-033 Abort: req=01, term0=9, drop req at count=4 -> IDLE next edge, gnt=00, count=4, done never pulses.
REQ-034 Term change: req=01, term0=2 at grant, term0 changed to 7 at count=1 -> done at count=2.
